// File: rtl/rom_linebuf.sv
// One-line (4 x 32-bit) read cache in front of a parallel flash ROM stage.
// Misses always fill words 0..3 in order; writes are acknowledged and discarded.
module rom_linebuf #(
    parameter int unsigned FILL_GAP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [23:0] addr,
    output logic [31:0] data_out,
    output logic        wt,
    input  logic        spi_en,
    output logic        rom_en,
    output logic        rom_wr,
    output logic [1:0]  rom_size,
    output logic [23:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_wt
);

    typedef enum logic [1:0] {StIdle, StFill, StGap, StResp} state_e;

    localparam logic [1:0] GapLast = 2'(FILL_GAP - 1);

    state_e      state_q, state_d;
    logic [19:0] tag_q, tag_d;
    logic        valid_q, valid_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  gap_q, gap_d;
    logic        spi_bad_q, spi_bad_d;
    logic [3:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] line_q [4];
    logic [31:0] line_d [4];
    logic [31:0] data_d;

    // Big-endian lane select; size 11 behaves as word.
    function automatic logic [31:0] lane_sel(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz);
        logic [31:0] r;
        case (sz)
            2'b00: begin
                case (off)
                    2'd0:    r = {24'b0, w[31:24]};
                    2'd1:    r = {24'b0, w[23:16]};
                    2'd2:    r = {24'b0, w[15:8]};
                    default: r = {24'b0, w[7:0]};
                endcase
            end
            2'b01:   r = off[1] ? {16'b0, w[15:0]} : {16'b0, w[31:16]};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        k_d       = k_q;
        gap_d     = gap_q;
        spi_bad_d = spi_bad_q;
        off_d     = off_q;
        size_d    = size_q;
        line_d    = line_q;
        data_d    = data_out;
        wt        = 1'b1;
        rom_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (spi_en) valid_d = 1'b0;
                if (en) begin
                    if (wr) begin
                        data_d  = '0;
                        state_d = StResp;
                    end else if (valid_q && tag_q == addr[23:4] && !spi_en) begin
                        data_d  = lane_sel(line_q[addr[3:2]], addr[1:0], size);
                        state_d = StResp;
                    end else begin
                        tag_d     = addr[23:4];
                        valid_d   = 1'b0;
                        k_d       = 2'd0;
                        spi_bad_d = 1'b0;
                        off_d     = addr[3:0];
                        size_d    = size;
                        state_d   = StFill;
                    end
                end
            end
            StFill: begin
                rom_en    = 1'b1;
                spi_bad_d = spi_bad_q | spi_en;
                if (!rom_wt) begin
                    line_d[k_q] = rom_data;
                    if (k_q == 2'd3) begin
                        // Word 3 arrives this cycle, so take it straight from the bus.
                        valid_d = !(spi_bad_q | spi_en);
                        data_d  = lane_sel((off_q[3:2] == 2'd3) ? rom_data : line_q[off_q[3:2]],
                                           off_q[1:0], size_q);
                        state_d = StResp;
                    end else begin
                        gap_d   = 2'd0;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                spi_bad_d = spi_bad_q | spi_en;
                if (gap_q == GapLast) begin
                    gap_d   = 2'd0;
                    k_d     = k_q + 2'd1;
                    state_d = StFill;
                end else begin
                    gap_d = gap_q + 2'd1;
                end
            end
            StResp: begin
                wt      = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            k_q       <= 2'd0;
            gap_q     <= 2'd0;
            spi_bad_q <= 1'b0;
            off_q     <= '0;
            size_q    <= '0;
            data_out  <= '0;
            for (int i = 0; i < 4; i++) line_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            k_q       <= k_d;
            gap_q     <= gap_d;
            spi_bad_q <= spi_bad_d;
            off_q     <= off_d;
            size_q    <= size_d;
            data_out  <= data_d;
            line_q    <= line_d;
        end
    end

    assign rom_wr   = 1'b0;
    assign rom_size = 2'b10;
    assign rom_addr = {tag_q, k_q, 2'b00};

endmodule

// File: tb/tb_rom_linebuf.sv
// Directed bench for rom_linebuf with a one-cycle-latency ROM stage model.
module tb_rom_linebuf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [23:0] addr = '0;
    logic [31:0] data_out;
    logic        wt;
    logic        spi_en = 1'b0;
    logic        rom_en;
    logic        rom_wr;
    logic [1:0]  rom_size;
    logic [23:0] rom_addr;
    logic [31:0] rom_data = '0;
    logic        rom_wt = 1'b1;

    int          n_vec = 0;
    int          n_err = 0;
    int          xfer_total = 0;
    logic [23:0] xfer_addr [16];

    rom_linebuf #(.FILL_GAP(1)) dut (
        .clk(clk), .reset(reset), .en(en), .wr(wr), .size(size), .addr(addr),
        .data_out(data_out), .wt(wt), .spi_en(spi_en), .rom_en(rom_en), .rom_wr(rom_wr),
        .rom_size(rom_size), .rom_addr(rom_addr), .rom_data(rom_data), .rom_wt(rom_wt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [23:0] a);
        case (a)
            24'h000100: return 32'h11111111;
            24'h000104: return 32'h22222222;
            24'h000108: return 32'h33333333;
            24'h00010C: return 32'h44444444;
            24'h000200: return 32'h01234567;
            24'h000204: return 32'h89ABCDEF;
            24'h000208: return 32'h02468ACE;
            24'h00020C: return 32'h13579BDF;
            default:    return 32'hDEADBEEF;
        endcase
    endfunction

    // ROM stage: answers one cycle after seeing a request.
    always @(posedge clk) begin
        if (rom_en && rom_wt) begin
            rom_wt   <= 1'b0;
            rom_data <= rom_word(rom_addr);
        end else begin
            rom_wt <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rom_en && !rom_wt) begin
            xfer_addr[xfer_total % 16] <= rom_addr;
            xfer_total <= xfer_total + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_access(input string tag, input logic w, input logic [1:0] sz,
                              input logic [23:0] a, input logic [31:0] exp_d,
                              input int exp_x, input int exp_lat);
        int x0;
        int lat;
        x0  = xfer_total;
        lat = 0;
        en = 1'b1; wr = w; size = sz; addr = a;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (wt && lat < 64);
        check_eq({tag, ":wt"}, {31'b0, wt}, 32'd0);
        check_eq({tag, ":data"}, data_out, exp_d);
        check_eq({tag, ":lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, ":xfers"}, 32'(xfer_total - x0), 32'(exp_x));
        // en still high across the response edge must not start a second access.
        @(posedge clk); #1;
        en = 1'b0;
        check_eq({tag, ":one"}, {31'b0, wt}, 32'd1);
        check_eq({tag, ":hold"}, data_out, exp_d);
    endtask

    task automatic fill_manual(input string tag, input logic [23:0] a, input int drop_at,
                               input int spi_at, input logic [31:0] exp_d);
        int x0;
        int n;
        x0 = xfer_total;
        n  = 0;
        en = 1'b1; wr = 1'b0; size = 2'b10; addr = a;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == drop_at) en = 1'b0;
            spi_en = (n == spi_at);
        end while (wt && n < 64);
        spi_en = 1'b0;
        en     = 1'b0;
        check_eq({tag, ":wt"}, {31'b0, wt}, 32'd0);
        check_eq({tag, ":data"}, data_out, exp_d);
        check_eq({tag, ":xfers"}, 32'(xfer_total - x0), 32'd4);
        @(posedge clk); #1;
        check_eq({tag, ":one"}, {31'b0, wt}, 32'd1);
    endtask

    initial begin
        int x0;
        int n;
        #2 reset = 1'b0;
        #1;
        check_eq("rst_wt", {31'b0, wt}, 32'd1);
        check_eq("rst_rom_en", {31'b0, rom_en}, 32'd0);
        check_eq("rst_rom_addr", {8'b0, rom_addr}, 32'd0);
        check_eq("rst_data", data_out, 32'd0);
        check_eq("rst_rom_wr", {31'b0, rom_wr}, 32'd0);
        check_eq("rst_rom_size", {30'b0, rom_size}, 32'd2);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Cold miss: four word requests in order with a one-cycle gap.
        x0 = xfer_total;
        run_access("cold", 1'b0, 2'b10, 24'h000104, 32'h22222222, 4, 12);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("cold_addr%0d", i), {8'b0, xfer_addr[(x0 + i) % 16]},
                     32'h100 + 32'(4 * i));

        run_access("hit_byte", 1'b0, 2'b00, 24'h00010D, 32'h00000044, 0, 1);
        run_access("hit_half", 1'b0, 2'b01, 24'h00010A, 32'h00003333, 0, 1);
        run_access("write", 1'b1, 2'b10, 24'h000100, 32'h00000000, 0, 1);
        run_access("after_wr", 1'b0, 2'b10, 24'h000100, 32'h11111111, 0, 1);
        run_access("size11", 1'b0, 2'b11, 24'h00010C, 32'h44444444, 0, 1);

        // SPI ownership in idle invalidates the line.
        spi_en = 1'b1;
        @(posedge clk); #1;
        spi_en = 1'b0;
        run_access("spi_idle", 1'b0, 2'b10, 24'h000100, 32'h11111111, 4, 12);

        run_access("line200", 1'b0, 2'b10, 24'h000200, 32'h01234567, 4, 12);
        run_access("b205", 1'b0, 2'b00, 24'h000205, 32'h000000AB, 0, 1);
        run_access("b20a", 1'b0, 2'b00, 24'h00020A, 32'h0000008A, 0, 1);
        run_access("b20f", 1'b0, 2'b00, 24'h00020F, 32'h000000DF, 0, 1);
        run_access("b200", 1'b0, 2'b00, 24'h000200, 32'h00000001, 0, 1);
        run_access("h20e", 1'b0, 2'b01, 24'h00020E, 32'h00009BDF, 0, 1);
        run_access("h204", 1'b0, 2'b01, 24'h000204, 32'h000089AB, 0, 1);
        run_access("w204", 1'b0, 2'b11, 24'h000204, 32'h89ABCDEF, 0, 1);
        run_access("replace", 1'b0, 2'b10, 24'h000100, 32'h11111111, 4, 12);

        // SPI during a fill: response delivered, line left invalid.
        fill_manual("spi_fill", 24'h000208, 0, 3, 32'h02468ACE);
        run_access("spi_refill", 1'b0, 2'b10, 24'h000208, 32'h02468ACE, 4, 12);

        // en dropped mid-fill: fill still completes and caches the line.
        fill_manual("en_drop", 24'h000104, 2, 0, 32'h22222222);
        run_access("en_drop_hit", 1'b0, 2'b10, 24'h000108, 32'h33333333, 0, 1);

        // Reset while word 2 is being requested.
        spi_en = 1'b1;
        @(posedge clk); #1;
        spi_en = 1'b0;
        n = 0;
        en = 1'b1; wr = 1'b0; size = 2'b10; addr = 24'h000100;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(rom_en && rom_addr == 24'h000108) && n < 64);
        check_eq("rst_fill_reach", {31'b0, rom_en}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("rst_fill_wt", {31'b0, wt}, 32'd1);
        check_eq("rst_fill_rom_en", {31'b0, rom_en}, 32'd0);
        check_eq("rst_fill_rom_addr", {8'b0, rom_addr}, 32'd0);
        check_eq("rst_fill_data", data_out, 32'd0);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_fill_hold_wt", {31'b0, wt}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        run_access("rst_refill", 1'b0, 2'b10, 24'h000100, 32'h11111111, 4, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
